// File: rtl/neuron_mac_pe.sv
// neuron_mac_pe -- streaming neuron processing element.
//
// Accepts N_IN weight/activation pairs over a valid/ready handshake. Each
// product (signed, 2*DW bits) is arithmetically right-shifted by `shif` and
// accumulated. Once the last pair has arrived, the bias is added and a leaky
// ReLU with slope/8 is applied. The result is then saturated to DW bits and
// held on y until the consumer takes it.
//
// Ports
//   clk, rst_n          clock, synchronous active-low reset
//   in_valid/in_ready   input handshake (in_ready == state is ACC)
//   w, x                signed weight / activation, DW bits
//   b                   signed bias, captured on the first beat
//   shif                per-product arithmetic right shift, taken every beat
//   slope               leaky slope in 1/8 units, captured on the first beat
//   out_valid/out_ready output handshake
//   y                   signed saturated result, DW bits
module neuron_mac_pe #(
  parameter int N_IN  = 4,
  parameter int DW    = 8,
  parameter int ACC_W = 20
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] w,
  input  logic [DW-1:0] x,
  input  logic [DW-1:0] b,
  input  logic [2:0]    shif,
  input  logic [2:0]    slope,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] y
);

  localparam int CW = (N_IN > 1) ? $clog2(N_IN) : 1;
  localparam int PW = 2 * DW;
  // One extra bit for the bias add, and four more for the 3-bit slope
  // multiply (treated as unsigned, so it gets a zero sign bit).
  localparam int SW = ACC_W + 1;
  localparam int LW = SW + 4;
  localparam logic signed [LW-1:0] YMAX = LW'((2 ** (DW - 1)) - 1);
  localparam logic signed [LW-1:0] YMIN = LW'(-(2 ** (DW - 1)));

  typedef enum logic [1:0] {S_ACC, S_ACT, S_OUT} state_t;

  state_t                    state;
  logic [CW-1:0]             cnt;
  logic signed [ACC_W-1:0]   acc;
  logic signed [DW-1:0]      b_q;
  logic [2:0]                slope_q;

  // Multiply-and-shift datapath. Operands are widened first so that the
  // full 2*DW product is formed.
  logic signed [PW-1:0]    w_ext, x_ext, prod, prod_sh;
  logic signed [ACC_W-1:0] prod_ext;

  assign w_ext    = PW'($signed(w));
  assign x_ext    = PW'($signed(x));
  assign prod     = w_ext * x_ext;
  assign prod_sh  = prod >>> shif;
  assign prod_ext = ACC_W'(prod_sh);

  // Activation datapath. It is evaluated in the ACT cycle from registered
  // state only.
  logic signed [SW-1:0] s;
  logic signed [LW-1:0] s_ext, slope_ext, leak, r, r_sat;

  assign s         = SW'(acc) + SW'(b_q);
  assign s_ext     = LW'(s);
  assign slope_ext = LW'($signed({1'b0, slope_q}));
  assign leak      = (s_ext * slope_ext) >>> 3;
  assign r         = (s > 0) ? s_ext : leak;
  assign r_sat     = (r > YMAX) ? YMAX : ((r < YMIN) ? YMIN : r);

  assign in_ready = (state == S_ACC);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_ACC;
      cnt       <= '0;
      acc       <= '0;
      b_q       <= '0;
      slope_q   <= '0;
      out_valid <= 1'b0;
      y         <= '0;
    end else begin
      case (state)
        S_ACC: begin
          if (in_valid) begin
            // The first beat loads the accumulator, so there is no separate
            // clear step between evaluations.
            if (cnt == '0) begin
              acc     <= prod_ext;
              b_q     <= $signed(b);
              slope_q <= slope;
            end else begin
              acc <= acc + prod_ext;
            end
            if (cnt == CW'(N_IN - 1)) begin
              cnt   <= '0;
              state <= S_ACT;
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
        end
        S_ACT: begin
          y         <= r_sat[DW-1:0];
          out_valid <= 1'b1;
          state     <= S_OUT;
        end
        S_OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= S_ACC;
          end
        end
        default: state <= S_ACC;
      endcase
    end
  end

endmodule

// File: doc/neuron_mac_pe.md
# neuron_mac_pe

Parametrised streaming neuron processing element with N_IN inputs. Weight/activation pairs arrive one per cycle over a valid/ready handshake and are multiplied and accumulated with a per-product shift. After the last pair, bias is added, a leaky ReLU is applied, and the result is saturated to the data width. The result is presented on a valid/ready output port. The block replaces the fixed two-input combinational neuron in the PE array and adds signed arithmetic, saturation, backpressure and an arbitrary fan-in.

## Interface
- N_IN, 4: pairs per neuron evaluation; legal range 1..16.
- DW, 8: width of w, x, b and y; signed two's complement, fixed point.
- ACC_W, 20: accumulator width; must satisfy ACC_W ≥ 2*DW + clog2(N_IN).
- CW, derived: clog2(N_IN), minimum 1; width of the beat counter.
- clk  in  1  single clock; all logic is on the rising edge.
- rst_n  in  1  synchronous, active-low reset.
- in_valid  in  1  the pair on w/x is valid.
- in_ready  out  1  the block accepts a pair; equals (state==ACC).
- w  in  DW  signed weight.
- x  in  DW  signed activation.
- b  in  DW  signed bias; sampled on the first beat of an evaluation.
- shif  in  3  arithmetic right shift applied to each product; sampled every beat.
- slope  in  3  leaky slope in units of 1/8; sampled on the first beat.
- out_valid  out  1  y holds a valid result.
- out_ready  in  1  the consumer accepts y.
- y  out  DW  signed, saturated result.

## Operation
- FSM states:
  - ACC (reset state). A beat is accepted when in_valid && in_ready. On each accepted beat: acc ← acc + sext((w*x) >>> shif), where the product is a signed 2*DW value and the shift is arithmetic.
  - On the first beat (cnt==0), acc is loaded with the shifted product rather than accumulated, and b and slope are captured.
  - On the beat where cnt==N_IN-1: move to ACT and clear cnt. Otherwise cnt ← cnt+1.
- ACT: one cycle.
  - s = acc + sext(b).
  - If s > 0, r = s; else r = (s * slope) >>> 3 (arithmetic shift, rounds toward −inf; s==0 gives r=0).
  - r is saturated to [−2^(DW−1), 2^(DW−1)−1] and registered into y.
  - Set out_valid=1 and go to OUT.
- OUT: y and out_valid hold steady until out_valid && out_ready. On that cycle, clear out_valid and return to ACC. No new pair is accepted in OUT, because in_ready=0.
- Accumulator overflow cannot occur when the ACC_W constraint is met. No wrap behaviour is defined.
- Reset (rst_n low at a clock edge):
  - state ← ACC, cnt ← 0, acc ← 0, out_valid ← 0, y ← 0.
  - Any partial evaluation is discarded.
  - in_valid is ignored on cycles where rst_n is low.
- Reset values of outputs: out_valid=0, y=0. in_ready=1 from the first edge with rst_n low onward, because state is ACC.

## Timing
- Only out_valid, y and in_ready (decoded from the state register) are visible outputs. No combinational path exists from in_valid or out_ready to any output.
- Latency: if the last pair is accepted at edge t, ACT runs in cycle t..t+1 and out_valid is high after edge t+1.
- Throughput with out_ready held high: one result every N_IN+2 cycles. That is N_IN accept cycles, 1 ACT cycle and 1 OUT cycle.
- in_valid may drop between beats. cnt and acc hold their values while no beat is accepted.
- When out_ready is low, y stays stable for the whole stall and in_ready stays 0.

## Test plan
- Basic (DW=8, N_IN=4, shif=3): 4 beats of w=16, x=8 with b=8 and out_ready=1 -> each product is 128>>>3=16; sum = 64+8 = 72; y=72, out_valid for 1 cycle, 2 cycles after the last beat.
- Positive saturation: 4 beats of w=127, x=127, shif=3, b=0 -> 2016 per beat, sum 8064; y=127.
- Leaky path: 4 beats of w=−16, x=8, shif=3, b=0.
  - slope=1 -> s=−64, y=−8.
  - slope=0 -> y=0.
  - Negative saturation: w=−128, x=127, shif=0, slope=7 -> y=−128.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid rises -> y is unchanged, in_ready=0, and in_valid pulses during the stall are not consumed. Raising out_ready gives one handshake, then in_ready=1 in the next cycle.
- Gapped input: insert idle cycles (in_valid=0) between the beats of the basic scenario -> the same y=72 is produced.
- Reset mid-operation: accept 2 beats, then drive rst_n=0 for 1 cycle -> out_valid=0, y=0. The next 4 beats of the basic stimulus give y=72, with no contribution from the discarded beats.
